// File: rtl/inst_dispatch_router.sv
// Buffered dispatch router: steers renamed instructions into per-FU FIFOs by fu_choice
// and snoops PRN wakeup broadcasts so that buffered operands become ready while they wait.

module inst_dispatch_chan #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int BUF_DEPTH    = 2,
    parameter int WAKE_PORTS   = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush_i,
    input  logic                                     push_i,
    input  logic [INST_ID_BITS-1:0]                  inst_id_i,
    input  logic [31:0]                              raw_instr_i,
    input  logic [63:0]                              instr_pc_i,
    input  logic [MAX_OPERANDS-1:0]                  piv_i,
    input  logic [MAX_OPERANDS-1:0]                  pir_i,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    pi_i,
    input  logic [MAX_OPERANDS-1:0]                  pov_i,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    po_i,
    input  logic [WAKE_PORTS-1:0]                    wake_valid_i,
    input  logic [WAKE_PORTS-1:0][PRN_BITS-1:0]      wake_prn_i,
    input  logic                                     out_ready_i,
    output logic                                     out_valid_o,
    output logic                                     queue_ready_o,
    output logic [INST_ID_BITS-1:0]                  inst_id_o,
    output logic [31:0]                              raw_instr_o,
    output logic [63:0]                              instr_pc_o,
    output logic [MAX_OPERANDS-1:0]                  piv_o,
    output logic [MAX_OPERANDS-1:0]                  pir_o,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    pi_o,
    output logic [MAX_OPERANDS-1:0]                  pov_o,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    po_o
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);

    typedef struct packed {
        logic [INST_ID_BITS-1:0]                  id;
        logic [31:0]                              raw;
        logic [63:0]                              pc;
        logic [MAX_OPERANDS-1:0]                  piv;
        logic [MAX_OPERANDS-1:0]                  pir;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    pi;
        logic [MAX_OPERANDS-1:0]                  pov;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    po;
    } entry_t;

    entry_t                                  mem_q [BUF_DEPTH];
    entry_t                                  push_entry;
    entry_t                                  head;
    logic [CW-1:0]                           count_q, count_d;
    logic [PW-1:0]                           head_q, head_d, tail_q, tail_d;
    logic [BUF_DEPTH-1:0][MAX_OPERANDS-1:0]  hit;
    logic                                    push, pop;

    assign out_valid_o   = (count_q != '0);
    assign queue_ready_o = (count_q < CNT_FULL);
    assign push = push_i && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;
    assign head = mem_q[head_q];

    assign push_entry = '{id: inst_id_i, raw: raw_instr_i, pc: instr_pc_i, piv: piv_i,
                          pir: pir_i, pi: pi_i, pov: pov_i, po: po_i};

    // Only operands that are in use can be woken; unused slots keep their bits.
    always_comb begin
        hit = '0;
        for (int e = 0; e < BUF_DEPTH; e++)
            for (int k = 0; k < MAX_OPERANDS; k++)
                for (int w = 0; w < WAKE_PORTS; w++)
                    if (mem_q[e].piv[k] && wake_valid_i[w] && wake_prn_i[w] == mem_q[e].pi[k])
                        hit[e][k] = 1'b1;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop)
            head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
        if (push)
            tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Payload needs no reset: idle outputs are masked by out_valid.
    always_ff @(posedge clk) begin
        for (int e = 0; e < BUF_DEPTH; e++) begin
            mem_q[e].pir <= mem_q[e].pir | hit[e];
            if (push && tail_q == PW'(e))
                mem_q[e] <= push_entry;
        end
    end

    // Head ready bits include this cycle's wakeups so a popping FU sees them.
    always_comb begin
        inst_id_o   = '0;
        raw_instr_o = '0;
        instr_pc_o  = '0;
        piv_o       = '0;
        pir_o       = '0;
        pi_o        = '0;
        pov_o       = '0;
        po_o        = '0;
        if (out_valid_o) begin
            inst_id_o   = head.id;
            raw_instr_o = head.raw;
            instr_pc_o  = head.pc;
            piv_o       = head.piv;
            pir_o       = head.pir | hit[head_q];
            pi_o        = head.pi;
            pov_o       = head.pov;
            po_o        = head.po;
        end
    end
endmodule

module inst_dispatch_router #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int FUC_BITS     = 2,
    parameter int BUF_DEPTH    = 2,
    parameter int WAKE_PORTS   = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [INST_ID_BITS-1:0]                             in_inst_id,
    input  logic [31:0]                                         in_raw_instr,
    input  logic [63:0]                                         in_instr_pc,
    input  logic [FUC_BITS-1:0]                                 in_fu_choice,
    input  logic [MAX_OPERANDS-1:0]                             in_prn_input_valid,
    input  logic [MAX_OPERANDS-1:0]                             in_prn_input_ready,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               in_prn_input,
    input  logic [MAX_OPERANDS-1:0]                             in_prn_output_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               in_prn_output,
    input  logic [WAKE_PORTS-1:0]                               wake_valid,
    input  logic [WAKE_PORTS-1:0][PRN_BITS-1:0]                 wake_prn,
    input  logic                                                flush,
    output logic [FU_COUNT-1:0]                                 out_valid,
    input  logic [FU_COUNT-1:0]                                 out_ready,
    output logic [FU_COUNT-1:0][INST_ID_BITS-1:0]               out_inst_id,
    output logic [FU_COUNT-1:0][31:0]                           out_raw_instr,
    output logic [FU_COUNT-1:0][63:0]                           out_instr_pc,
    output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               out_prn_input_valid,
    output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               out_prn_input_ready,
    output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn_input,
    output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               out_prn_output_valid,
    output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn_output,
    output logic [FU_COUNT-1:0]                                 queue_ready,
    output logic                                                route_err
);
    localparam logic [FUC_BITS:0] FU_LIM = (FUC_BITS + 1)'(FU_COUNT);

    logic                    legal, sel_qready, push, route_err_q;
    logic [MAX_OPERANDS-1:0] in_pir_woken;

    assign legal = ({1'b0, in_fu_choice} < FU_LIM);

    // Accept decision uses registered occupancy only, never out_ready.
    always_comb begin
        sel_qready = 1'b0;
        for (int i = 0; i < FU_COUNT; i++)
            if (in_fu_choice == FUC_BITS'(i))
                sel_qready = queue_ready[i];
    end

    assign in_ready = !flush && (legal ? sel_qready : 1'b1);
    assign push     = in_valid && in_ready;

    always_comb begin
        in_pir_woken = in_prn_input_ready;
        for (int k = 0; k < MAX_OPERANDS; k++)
            for (int w = 0; w < WAKE_PORTS; w++)
                if (in_prn_input_valid[k] && wake_valid[w] && wake_prn[w] == in_prn_input[k])
                    in_pir_woken[k] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            route_err_q <= 1'b0;
        else
            route_err_q <= push && !legal;
    end

    assign route_err = route_err_q;

    for (genvar g = 0; g < FU_COUNT; g++) begin : g_chan
        inst_dispatch_chan #(
            .INST_ID_BITS (INST_ID_BITS),
            .PRN_BITS     (PRN_BITS),
            .MAX_OPERANDS (MAX_OPERANDS),
            .BUF_DEPTH    (BUF_DEPTH),
            .WAKE_PORTS   (WAKE_PORTS)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .flush_i       (flush),
            .push_i        (push && legal && in_fu_choice == FUC_BITS'(g)),
            .inst_id_i     (in_inst_id),
            .raw_instr_i   (in_raw_instr),
            .instr_pc_i    (in_instr_pc),
            .piv_i         (in_prn_input_valid),
            .pir_i         (in_pir_woken),
            .pi_i          (in_prn_input),
            .pov_i         (in_prn_output_valid),
            .po_i          (in_prn_output),
            .wake_valid_i  (wake_valid),
            .wake_prn_i    (wake_prn),
            .out_ready_i   (out_ready[g]),
            .out_valid_o   (out_valid[g]),
            .queue_ready_o (queue_ready[g]),
            .inst_id_o     (out_inst_id[g]),
            .raw_instr_o   (out_raw_instr[g]),
            .instr_pc_o    (out_instr_pc[g]),
            .piv_o         (out_prn_input_valid[g]),
            .pir_o         (out_prn_input_ready[g]),
            .pi_o          (out_prn_input[g]),
            .pov_o         (out_prn_output_valid[g]),
            .po_o          (out_prn_output[g])
        );
    end
endmodule

// File: tb/tb_inst_dispatch_router.sv
// Directed bench for inst_dispatch_router: a 4-channel instance for the main flow
// and a 3-channel instance sharing the inputs for the illegal-route case.

module tb_inst_dispatch_router;
    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [5:0]           in_inst_id;
    logic [31:0]          in_raw_instr;
    logic [63:0]          in_instr_pc;
    logic [1:0]           in_fu_choice;
    logic [2:0]           in_piv, in_pir, in_pov;
    logic [2:0][5:0]      in_pi, in_po;
    logic [3:0]           wake_valid;
    logic [3:0][5:0]      wake_prn;
    logic                 flush;
    logic [3:0]           out_ready;

    logic                 in_ready;
    logic [3:0]           out_valid, queue_ready;
    logic [3:0][5:0]      out_inst_id;
    logic [3:0][31:0]     out_raw_instr;
    logic [3:0][63:0]     out_instr_pc;
    logic [3:0][2:0]      o_piv, o_pir, o_pov;
    logic [3:0][2:0][5:0] o_pi, o_po;
    logic                 route_err;

    logic                 in_ready3;
    logic [2:0]           out_valid3, queue_ready3;
    logic [2:0][5:0]      out_inst_id3;
    logic [2:0][31:0]     out_raw_instr3;
    logic [2:0][63:0]     out_instr_pc3;
    logic [2:0][2:0]      o3_piv, o3_pir, o3_pov;
    logic [2:0][2:0][5:0] o3_pi, o3_po;
    logic                 route_err3;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_dispatch_router u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr), .in_instr_pc(in_instr_pc),
        .in_fu_choice(in_fu_choice), .in_prn_input_valid(in_piv), .in_prn_input_ready(in_pir),
        .in_prn_input(in_pi), .in_prn_output_valid(in_pov), .in_prn_output(in_po),
        .wake_valid(wake_valid), .wake_prn(wake_prn), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst_id(out_inst_id),
        .out_raw_instr(out_raw_instr), .out_instr_pc(out_instr_pc),
        .out_prn_input_valid(o_piv), .out_prn_input_ready(o_pir), .out_prn_input(o_pi),
        .out_prn_output_valid(o_pov), .out_prn_output(o_po),
        .queue_ready(queue_ready), .route_err(route_err)
    );

    inst_dispatch_router #(.FU_COUNT(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr), .in_instr_pc(in_instr_pc),
        .in_fu_choice(in_fu_choice), .in_prn_input_valid(in_piv), .in_prn_input_ready(in_pir),
        .in_prn_input(in_pi), .in_prn_output_valid(in_pov), .in_prn_output(in_po),
        .wake_valid(wake_valid), .wake_prn(wake_prn), .flush(flush),
        .out_valid(out_valid3), .out_ready(out_ready[2:0]), .out_inst_id(out_inst_id3),
        .out_raw_instr(out_raw_instr3), .out_instr_pc(out_instr_pc3),
        .out_prn_input_valid(o3_piv), .out_prn_input_ready(o3_pir), .out_prn_input(o3_pi),
        .out_prn_output_valid(o3_pov), .out_prn_output(o3_po),
        .queue_ready(queue_ready3), .route_err(route_err3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [1:0] fu, input logic [5:0] id);
        in_valid     = 1'b1;
        in_fu_choice = fu;
        in_inst_id   = id;
        in_raw_instr = {26'h0, id} ^ 32'hA5A5_0000;
        in_instr_pc  = 64'h1000 + {58'h0, id};
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst_id = '0; in_raw_instr = '0; in_instr_pc = '0;
        in_fu_choice = '0; in_piv = '0; in_pir = '0; in_pov = '0; in_pi = '0; in_po = '0;
        wake_valid = '0; wake_prn = '0; flush = 1'b0; out_ready = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_queue_ready", 64'(queue_ready), 64'hF);
        chk("reset_route_err", 64'(route_err), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h1);

        // single push to FU2
        set_push(2'd2, 6'd5);
        chk("push5_in_ready", 64'(in_ready), 64'h1);
        tick(); in_valid = 1'b0; #1;
        chk("push5_out_valid", 64'(out_valid), 64'h4);
        chk("push5_id", 64'(out_inst_id[2]), 64'd5);
        chk("push5_raw", 64'(out_raw_instr[2]), 64'hA5A5_0005);
        chk("push5_pc", out_instr_pc[2], 64'h1005);
        chk("push5_idle_id0", 64'(out_inst_id[0]), 64'h0);
        chk("push5_idle_pc1", out_instr_pc[1], 64'h0);
        out_ready = 4'b0100;
        tick(); out_ready = '0; #1;
        chk("push5_drained", 64'(out_valid), 64'h0);

        // fill FU1, backpressure isolation
        set_push(2'd1, 6'd1); tick();
        set_push(2'd1, 6'd2); tick();
        in_valid = 1'b0; #1;
        chk("fu1_full_qready", 64'(queue_ready), 64'hD);
        set_push(2'd1, 6'd3);
        chk("fu1_full_in_ready", 64'(in_ready), 64'h0);
        in_fu_choice = 2'd0; #1;
        chk("fu0_free_in_ready", 64'(in_ready), 64'h1);
        in_valid = 1'b0;
        out_ready = 4'b0010; #1;
        chk("fu1_head1", 64'(out_inst_id[1]), 64'd1);
        tick();
        chk("fu1_head2", 64'(out_inst_id[1]), 64'd2);
        tick();
        chk("fu1_empty", 64'(out_valid), 64'h0);
        out_ready = '0;

        // wakeup of stored entry; op2 unused but names the same PRN
        in_piv = 3'b011; in_pir = 3'b000;
        in_pi[0] = 6'd17; in_pi[1] = 6'd20; in_pi[2] = 6'd17;
        set_push(2'd0, 6'd7); tick();
        in_valid = 1'b0; #1;
        chk("wake_before", 64'(o_pir[0]), 64'h0);
        wake_valid = 4'b1000; wake_prn[3] = 6'd17; #1;
        chk("wake_fwd", 64'(o_pir[0]), 64'h1);
        tick();
        wake_valid = '0; #1;
        chk("wake_sticky", 64'(o_pir[0]), 64'h1);
        chk("wake_prn0", 64'(o_pi[0][0]), 64'd17);

        // push bypass: wake arrives in the push cycle
        in_piv = 3'b001; in_pi[0] = 6'd30; in_pi[2] = 6'd0;
        wake_valid = 4'b0001; wake_prn[0] = 6'd30;
        set_push(2'd2, 6'd6); tick();
        in_valid = 1'b0; wake_valid = '0; in_piv = '0; #1;
        chk("bypass_ready", 64'(o_pir[2]), 64'h1);
        out_ready = 4'b0101;
        tick(); out_ready = '0; #1;
        chk("wake_drained", 64'(out_valid), 64'h0);

        // simultaneous push and pop on FU3
        set_push(2'd3, 6'd8); tick();
        out_ready = 4'b1000;
        set_push(2'd3, 6'd9);
        chk("pp_in_ready", 64'(in_ready), 64'h1);
        chk("pp_head8", 64'(out_inst_id[3]), 64'd8);
        tick();
        in_valid = 1'b0; out_ready = '0; #1;
        chk("pp_valid", 64'(out_valid), 64'h8);
        chk("pp_head9", 64'(out_inst_id[3]), 64'd9);
        chk("pp_count1", 64'(queue_ready[3]), 64'h1);
        set_push(2'd3, 6'd10); tick();
        in_valid = 1'b0; #1;
        chk("pp_full", 64'(queue_ready[3]), 64'h0);

        // flush with FU0, FU2, FU3 occupied
        set_push(2'd0, 6'd11); tick();
        set_push(2'd2, 6'd12); tick();
        set_push(2'd1, 6'd13);
        flush = 1'b1; out_ready = 4'hF; #1;
        chk("flush_in_ready", 64'(in_ready), 64'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = '0; #1;
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_qready", 64'(queue_ready), 64'hF);

        // illegal route on the 3-channel instance
        rst = 1'b1; tick(); rst = 1'b0;
        set_push(2'd3, 6'd14);
        chk("illegal_in_ready", 64'(in_ready3), 64'h1);
        tick();
        in_valid = 1'b0; #1;
        chk("illegal_err", 64'(route_err3), 64'h1);
        chk("illegal_no_valid", 64'(out_valid3), 64'h0);
        tick();
        chk("illegal_err_pulse", 64'(route_err3), 64'h0);
        set_push(2'd3, 6'd15);
        flush = 1'b1; #1;
        chk("illegal_flush_in_ready", 64'(in_ready3), 64'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0; #1;
        chk("illegal_flush_no_err", 64'(route_err3), 64'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
